// File: rtl/vec_row_feeder_pkg.sv
// Shared types for the vector row feeder.
// Provides defaults for the element count and element width when the build does not supply
// MAX_EMBEDDING_DIM / INTEGER_WIDTH, the vector type, the feeder FSM state enum and a helper
// that sums FIFO occupancy and in-flight reads into a credit count.
// No ports (package).

`ifndef MAX_EMBEDDING_DIM
`define MAX_EMBEDDING_DIM 4
`endif
`ifndef INTEGER_WIDTH
`define INTEGER_WIDTH 16
`endif

package vec_row_feeder_pkg;

    localparam int unsigned VEC_LEN_DEF    = `MAX_EMBEDDING_DIM;
    localparam int unsigned DATA_WIDTH_DEF = `INTEGER_WIDTH;

    typedef logic [VEC_LEN_DEF-1:0][DATA_WIDTH_DEF-1:0] vec_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } feeder_state_e;

    // Slots committed once this cycle's pop has drained: stored + in flight - popping now.
    function automatic logic [2:0] credits_used(input logic [1:0] occ, input logic inflight,
                                                input logic pop);
        return {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    endfunction

endpackage

// File: rtl/vec_fifo2.sv
// Two-entry vector FIFO used as the output skid buffer of the row feeder.
// Ports:
//   i_clk, i_rst    clock, synchronous active-high reset (empties the FIFO)
//   i_push, i_data  write one vector
//   i_pop           remove the head (caller guarantees non-empty)
//   o_full, o_empty occupancy flags
//   o_head          current head vector, held until popped

module vec_fifo2
    import vec_row_feeder_pkg::*;
#(
    parameter int unsigned VEC_LEN    = VEC_LEN_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_push,
    input  logic [VEC_LEN-1:0][DATA_WIDTH-1:0]  i_data,
    input  logic                                i_pop,
    output logic                                o_full,
    output logic                                o_empty,
    output logic [VEC_LEN-1:0][DATA_WIDTH-1:0]  o_head
);

    logic [VEC_LEN-1:0][DATA_WIDTH-1:0] r_mem [2];
    logic                               r_wptr;
    logic                               r_rptr;
    logic [1:0]                         r_cnt;

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_cnt  <= 2'd0;
        end else begin
            if (i_push) begin
                r_wptr <= ~r_wptr;
            end
            if (i_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_full  = (r_cnt == 2'd2);
    assign o_empty = (r_cnt == 2'd0);
    assign o_head  = r_mem[r_rptr];

endmodule

// File: rtl/vec_row_feeder.sv
// Vector row feeder: accepts (base, rows) commands, reads rows from a 1-cycle-latency SRAM port
// and streams them out as vectors under vld_out/rdy_in backpressure at up to one per cycle.
// Ports:
//   clk, rst             clock, synchronous active-high reset (aborts any command)
//   cmd_vld/cmd_rdy      command handshake; cmd_rdy high only when idle
//   cmd_base, cmd_rows   first row address, number of rows (0 allowed)
//   mem_ren, mem_addr    SRAM read request
//   mem_rdata            SRAM data, valid the cycle after mem_ren
//   vld_out/rdy_in       output vector handshake
//   vec_out              output vector (FIFO head)
//   last                 only with VEC_ROW_FEEDER_LAST_EN: marks the final vector of a command
//   done                 one-cycle pulse after the final handshake of a command
// Build option: define VEC_ROW_FEEDER_LAST_EN to add the last port.

module vec_row_feeder
    import vec_row_feeder_pkg::*;
#(
    parameter int unsigned VEC_LEN    = VEC_LEN_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cmd_vld,
    output logic                               cmd_rdy,
    input  logic [ADDR_WIDTH-1:0]              cmd_base,
    input  logic [CNT_WIDTH-1:0]               cmd_rows,
    output logic                               mem_ren,
    output logic [ADDR_WIDTH-1:0]              mem_addr,
    input  logic [VEC_LEN-1:0][DATA_WIDTH-1:0] mem_rdata,
    output logic                               vld_out,
    input  logic                               rdy_in,
    output logic [VEC_LEN-1:0][DATA_WIDTH-1:0] vec_out,
`ifdef VEC_ROW_FEEDER_LAST_EN
    output logic                               last,
`endif
    output logic                               done
);

    feeder_state_e         r_state;
    feeder_state_e         w_state_d;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CNT_WIDTH-1:0]  r_issue_left;
    logic [CNT_WIDTH-1:0]  r_out_left;
    logic                  r_inflight;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_accept;
    logic [1:0]            w_occ;
    logic [2:0]            w_credit;

    vec_fifo2 #(
        .VEC_LEN    (VEC_LEN),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (r_inflight),
        .i_data  (mem_rdata),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (vec_out)
    );

    assign vld_out  = ~w_empty;
    assign w_pop    = vld_out & rdy_in;
    assign w_accept = cmd_vld & cmd_rdy;
    assign w_occ    = {w_full, ~w_full & ~w_empty};
    // A read may issue only if its data is guaranteed a FIFO slot when it lands next cycle.
    assign w_credit = credits_used(w_occ, r_inflight, w_pop);
    assign mem_addr = r_addr;
    assign done     = (r_state == StDone);

`ifdef VEC_ROW_FEEDER_LAST_EN
    assign last = vld_out & (r_out_left == CNT_WIDTH'(1));
`endif

    always_comb begin
        w_state_d = r_state;
        cmd_rdy   = 1'b0;
        mem_ren   = 1'b0;
        unique case (r_state)
            StIdle: begin
                cmd_rdy = 1'b1;
                if (cmd_vld) begin
                    w_state_d = (cmd_rows == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                mem_ren = (r_issue_left != '0) && (w_credit < 3'd2);
                if (w_pop && (r_out_left == CNT_WIDTH'(1))) begin
                    w_state_d = StDone;
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_addr       <= '0;
            r_issue_left <= '0;
            r_out_left   <= '0;
            r_inflight   <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_inflight <= mem_ren;
            if (w_accept) begin
                r_addr       <= cmd_base;
                r_issue_left <= cmd_rows;
                r_out_left   <= cmd_rows;
            end else begin
                if (mem_ren) begin
                    r_addr       <= r_addr + ADDR_WIDTH'(1);
                    r_issue_left <= r_issue_left - CNT_WIDTH'(1);
                end
                if (w_pop) begin
                    r_out_left <= r_out_left - CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_vec_row_feeder.sv
module tb_vec_row_feeder;
    import vec_row_feeder_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_vld;
    logic       cmd_rdy;
    logic [7:0] cmd_base;
    logic [7:0] cmd_rows;
    logic       mem_ren;
    logic [7:0] mem_addr;
    vec_t       mem_rdata;
    logic       vld_out;
    logic       rdy_in;
    vec_t       vec_out;
    logic       done;
`ifdef VEC_ROW_FEEDER_LAST_EN
    logic       last;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    vec_row_feeder #(
        .VEC_LEN    (VEC_LEN_DEF),
        .DATA_WIDTH (DATA_WIDTH_DEF),
        .ADDR_WIDTH (8),
        .CNT_WIDTH  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_vld   (cmd_vld),
        .cmd_rdy   (cmd_rdy),
        .cmd_base  (cmd_base),
        .cmd_rows  (cmd_rows),
        .mem_ren   (mem_ren),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .vld_out   (vld_out),
        .rdy_in    (rdy_in),
        .vec_out   (vec_out),
`ifdef VEC_ROW_FEEDER_LAST_EN
        .last      (last),
`endif
        .done      (done)
    );

    // Row contents: element i of row a is {a, i}.
    function automatic vec_t row_of(input logic [7:0] a);
        vec_t v;
        for (int i = 0; i < int'(VEC_LEN_DEF); i++) begin
            v[i] = DATA_WIDTH_DEF'((32'(a) << 8) | 32'(i));
        end
        return v;
    endfunction

    // 1-cycle-latency SRAM model.
    initial mem_rdata = '0;
    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= row_of(mem_addr);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns just after the accepting edge (cycle k=0 of the command).
    task automatic issue(input logic [7:0] base, input logic [7:0] rows);
        cmd_vld  = 1'b1;
        cmd_base = base;
        cmd_rows = rows;
        @(posedge clk);
        #1;
        cmd_vld  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_vld = 1'b0; cmd_base = 8'h00; cmd_rows = 8'h00; rdy_in = 1'b0;
        step();
        step();
        n_checks++; if (cmd_rdy !== 1'b1) begin n_errors++; $display("FAIL reset_cmd_rdy got %0b want 1", cmd_rdy); end
        n_checks++; if (mem_ren !== 1'b0) begin n_errors++; $display("FAIL reset_mem_ren got %0b want 0", mem_ren); end
        n_checks++; if (mem_addr !== 8'h00) begin n_errors++; $display("FAIL reset_mem_addr got %0h want 0", mem_addr); end
        n_checks++; if (vld_out !== 1'b0) begin n_errors++; $display("FAIL reset_vld_out got %0b want 0", vld_out); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done got %0b want 0", done); end
`ifdef VEC_ROW_FEEDER_LAST_EN
        n_checks++; if (last !== 1'b0) begin n_errors++; $display("FAIL reset_last got %0b want 0", last); end
`endif
        rst = 1'b0;
        step();
    endtask

    // Rows 0x10..0x13, rdy held high: reads at k=0..3, vectors at k=2..5, done at k=6.
    task automatic test_stream();
        logic [7:0] a;
        rdy_in = 1'b1;
        issue(8'h10, 8'd4);
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (mem_ren !== (k <= 3)) begin
                n_errors++; $display("FAIL stream_ren k=%0d got %0b want %0b", k, mem_ren, k <= 3);
            end
            if (k <= 3) begin
                a = 8'(8'h10 + k);
                n_checks++;
                if (mem_addr !== a) begin
                    n_errors++; $display("FAIL stream_addr k=%0d got %0h want %0h", k, mem_addr, a);
                end
            end
            n_checks++;
            if (vld_out !== (k >= 2 && k <= 5)) begin
                n_errors++; $display("FAIL stream_vld k=%0d got %0b want %0b", k, vld_out, k >= 2 && k <= 5);
            end
            if (k >= 2 && k <= 5) begin
                a = 8'(8'h10 + k - 2);
                n_checks++;
                if (vec_out !== row_of(a)) begin
                    n_errors++; $display("FAIL stream_vec k=%0d got %0h want %0h", k, vec_out, row_of(a));
                end
            end
            n_checks++;
            if (done !== (k == 6)) begin
                n_errors++; $display("FAIL stream_done k=%0d got %0b want %0b", k, done, k == 6);
            end
            n_checks++;
            if (cmd_rdy !== (k == 7)) begin
                n_errors++; $display("FAIL stream_cmd_rdy k=%0d got %0b want %0b", k, cmd_rdy, k == 7);
            end
            step();
        end
    endtask

    // Rows 0x20..0x24 with rdy_in toggling 1,0,1,0...
    task automatic test_backpressure();
        int   idx = 0;
        int   issued = 0;
        int   popped = 0;
        logic seen_done = 1'b0;
        logic prev_stall = 1'b0;
        logic pop;
        vec_t prev_vec = '0;
        rdy_in = 1'b1;
        issue(8'h20, 8'd5);
        for (int k = 0; k < 40 && !seen_done; k++) begin
            rdy_in = ((k % 2) == 0);
            #1;
            pop = vld_out & rdy_in;
            if (prev_stall) begin
                n_checks++;
                if (vld_out !== 1'b1 || vec_out !== prev_vec) begin
                    n_errors++;
                    $display("FAIL bp_hold k=%0d got vld=%0b vec=%0h want vld=1 vec=%0h", k, vld_out, vec_out, prev_vec);
                end
            end
            if (mem_ren === 1'b1) begin
                n_checks++;
                if (issued - popped - int'(pop) >= 2) begin
                    n_errors++;
                    $display("FAIL bp_credit k=%0d got outstanding=%0d want <2", k, issued - popped - int'(pop));
                end
                n_checks++;
                if (mem_addr !== 8'(8'h20 + issued)) begin
                    n_errors++; $display("FAIL bp_addr k=%0d got %0h want %0h", k, mem_addr, 8'(8'h20 + issued));
                end
                issued++;
            end
            if (pop) begin
                n_checks++;
                if (vec_out !== row_of(8'(8'h20 + idx))) begin
                    n_errors++;
                    $display("FAIL bp_vec idx=%0d got %0h want %0h", idx, vec_out, row_of(8'(8'h20 + idx)));
                end
                idx++;
                popped++;
            end
            if (done === 1'b1) seen_done = 1'b1;
            prev_stall = vld_out & ~rdy_in;
            prev_vec   = vec_out;
            @(posedge clk);
            #1;
        end
        n_checks++; if (!seen_done) begin n_errors++; $display("FAIL bp_done got none want pulse"); end
        n_checks++; if (idx != 5) begin n_errors++; $display("FAIL bp_count got %0d want 5", idx); end
        n_checks++; if (issued != 5) begin n_errors++; $display("FAIL bp_issued got %0d want 5", issued); end
        rdy_in = 1'b1;
        step();
    endtask

    // Rows 0xFE,0xFF,0x00: address wraps.
    task automatic test_wrap();
        logic [7:0] exp_a [3];
        exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00;
        rdy_in = 1'b1;
        issue(8'hFE, 8'd3);
        for (int k = 0; k < 6; k++) begin
            if (k < 3) begin
                n_checks++;
                if (mem_ren !== 1'b1 || mem_addr !== exp_a[k]) begin
                    n_errors++;
                    $display("FAIL wrap_addr k=%0d got ren=%0b addr=%0h want ren=1 addr=%0h", k, mem_ren, mem_addr, exp_a[k]);
                end
            end
            if (k >= 2 && k <= 4) begin
                n_checks++;
                if (vld_out !== 1'b1 || vec_out !== row_of(exp_a[k-2])) begin
                    n_errors++;
                    $display("FAIL wrap_vec k=%0d got vld=%0b vec=%0h want %0h", k, vld_out, vec_out, row_of(exp_a[k-2]));
                end
            end
            if (k == 5) begin
                n_checks++;
                if (done !== 1'b1) begin n_errors++; $display("FAIL wrap_done got %0b want 1", done); end
            end
            step();
        end
    endtask

    task automatic test_zero_rows();
        rdy_in = 1'b1;
        issue(8'h33, 8'd0);
        n_checks++; if (cmd_rdy !== 1'b0) begin n_errors++; $display("FAIL zero_cmd_rdy0 got %0b want 0", cmd_rdy); end
        n_checks++; if (mem_ren !== 1'b0) begin n_errors++; $display("FAIL zero_ren0 got %0b want 0", mem_ren); end
        n_checks++; if (vld_out !== 1'b0) begin n_errors++; $display("FAIL zero_vld0 got %0b want 0", vld_out); end
        n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL zero_done0 got %0b want 1", done); end
        step();
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL zero_done1 got %0b want 0", done); end
        n_checks++; if (cmd_rdy !== 1'b1) begin n_errors++; $display("FAIL zero_cmd_rdy1 got %0b want 1", cmd_rdy); end
        n_checks++; if (mem_ren !== 1'b0 || vld_out !== 1'b0) begin
            n_errors++; $display("FAIL zero_idle got ren=%0b vld=%0b want 0 0", mem_ren, vld_out);
        end
        step();
    endtask

    // Abort after 2 of 6 vectors, then a clean 2-row command.
    task automatic test_reset_mid();
        rdy_in = 1'b1;
        issue(8'h50, 8'd6);
        for (int k = 0; k < 4; k++) step();
        rst = 1'b1;
        step();
        n_checks++; if (vld_out !== 1'b0) begin n_errors++; $display("FAIL abort_vld got %0b want 0", vld_out); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL abort_done got %0b want 0", done); end
        n_checks++; if (cmd_rdy !== 1'b1) begin n_errors++; $display("FAIL abort_cmd_rdy got %0b want 1", cmd_rdy); end
        rst = 1'b0;
        step();
        step();
        n_checks++; if (vld_out !== 1'b0 || done !== 1'b0 || mem_ren !== 1'b0) begin
            n_errors++; $display("FAIL abort_quiet got vld=%0b done=%0b ren=%0b want 0 0 0", vld_out, done, mem_ren);
        end
        issue(8'h60, 8'd2);
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (mem_ren !== (k <= 1)) begin
                n_errors++; $display("FAIL post_ren k=%0d got %0b want %0b", k, mem_ren, k <= 1);
            end
            n_checks++;
            if (vld_out !== (k == 2 || k == 3)) begin
                n_errors++; $display("FAIL post_vld k=%0d got %0b want %0b", k, vld_out, k == 2 || k == 3);
            end
            if (k == 2 || k == 3) begin
                n_checks++;
                if (vec_out !== row_of(8'(8'h60 + k - 2))) begin
                    n_errors++; $display("FAIL post_vec k=%0d got %0h want %0h", k, vec_out, row_of(8'(8'h60 + k - 2)));
                end
            end
            n_checks++;
            if (done !== (k == 4)) begin
                n_errors++; $display("FAIL post_done k=%0d got %0b want %0b", k, done, k == 4);
            end
            step();
        end
    endtask

`ifdef VEC_ROW_FEEDER_LAST_EN
    task automatic test_last();
        int   idx = 0;
        logic seen_done = 1'b0;
        rdy_in = 1'b0;
        issue(8'h70, 8'd3);
        for (int k = 0; k < 30 && !seen_done; k++) begin
            rdy_in = (k >= 5);
            #1;
            n_checks++;
            if (last !== (vld_out && idx == 2)) begin
                n_errors++; $display("FAIL last_flag k=%0d got %0b want %0b", k, last, vld_out && idx == 2);
            end
            if (vld_out && rdy_in) begin
                n_checks++;
                if (vec_out !== row_of(8'(8'h70 + idx))) begin
                    n_errors++; $display("FAIL last_vec idx=%0d got %0h want %0h", idx, vec_out, row_of(8'(8'h70 + idx)));
                end
                idx++;
            end
            if (done === 1'b1) seen_done = 1'b1;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (!seen_done || idx != 3) begin
            n_errors++; $display("FAIL last_count got done=%0b n=%0d want done=1 n=3", seen_done, idx);
        end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_wrap();
        test_zero_rows();
        test_reset_mid();
`ifdef VEC_ROW_FEEDER_LAST_EN
        test_last();
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
